codificador_instrucoes: RTL
===========================

Name: codificador_instrucoes

Overview:
Encoder and loader for the instruction memory: the write-side counterpart of the fetch/decode path. Accepts one field-level instruction per handshake (op select, rd, rs1, rs2, imm) and packs it into a 32-bit RV32I word. Emits the words as sequential writes starting at address 0, through a one-entry registered output stage with backpressure. Supports the processor's subset only: ADD, OR, SLL, ADDI, LH, SH, BNE.

Parameters:
DEPTH, 50, number of instruction words in the target memory; writes stop when this many have been issued.
ADDR_W, 6, width of wr_addr; must satisfy 2**ADDR_W >= DEPTH.

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
limpar  in  1  synchronous clear: restart loading at address 0
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept the bundle this cycle
in_op  in  3  0 ADD, 1 OR, 2 SLL, 3 ADDI, 4 LH, 5 SH, 6 BNE, 7 reserved
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2 (the shamt field for SLL)
in_imm  in  12  ADDI/LH/SH: imm[11:0]; BNE: byte offset[12:1]
wr_valid  out  1  memory write pending
wr_ready  in  1  memory accepts the write this cycle
wr_addr  out  ADDR_W  word address of the pending write
wr_data  out  32  encoded instruction
contagem  out  ADDR_W+1  words accepted by the memory so far
cheio  out  1  DEPTH words have been issued; no further input is accepted
erro_op  out  1  sticky flag: a reserved op was received

Behaviour:
- Reset (asynchronous) values: in_ready=0 while reset is asserted, wr_valid=0, wr_addr=0, wr_data=0, contagem=0, cheio=0, erro_op=0. The internal next-address counter prox=0.
- in_ready = !reset && !limpar && !cheio && (!wr_valid || wr_ready). The input is accepted when in_valid && in_ready.
- Acceptance with a valid op: at that edge the encoded word is written to wr_data, wr_addr<=prox, wr_valid<=1, and prox increments. Latency is 1 cycle from acceptance to wr_valid.
- Throughput: 1 word per cycle while wr_ready is held high.
- Write completion: wr_valid && wr_ready at an edge increments contagem. wr_valid is cleared unless a new word is accepted at the same edge.
- Hold rule: while wr_valid=1 and wr_ready=0, wr_addr and wr_data stay stable.
- Encoding fields:
  - R-type (ADD/OR/SLL): {funct7=0, rs2, rs1, funct3, rd, 0110011}, where funct3 is ADD 000, OR 110, SLL 001.
  - I-type: {imm[11:0], rs1, funct3, rd, opcode}. ADDI uses 000/0010011; LH uses 001/0000011.
  - SH (S-type): {imm[11:5], rs2, rs1, 001, imm[4:0], 0100011}.
  - BNE (standard B-type), with o = in_imm: {o[11], o[9:4], rs2, rs1, 001, o[3:0], o[10], 1100011}.
- Unused fields for each op are ignored and never leak into the word; for example, in_rd is ignored for SH/BNE.
- Reserved op (7): the bundle is consumed (handshake completes), no word is emitted, prox is unchanged, and erro_op<=1 (sticky until reset or limpar).
- cheio is set at the edge where prox becomes DEPTH. From then on in_ready=0. Any pending write still completes normally.
- limpar: synchronous. At that edge prox, contagem, erro_op and cheio are cleared and wr_valid is dropped, so a pending write is discarded. in_ready=0 during limpar, so a simultaneous in_valid is not accepted. limpar has priority over all other events.
- Reset mid-write: the pending word is lost, and after reset release loading restarts at address 0.
- contagem never exceeds DEPTH, and prox never wraps.

Decomposition:
- Shared package: the in_op enum; the opcode constants (0110011, 0010011, 0000011, 0100011, 1100011); the funct3/funct7 constants. The instruction-memory decoder uses the same package.
- One sub-module, codificador_campos: purely combinational. It maps (op, rd, rs1, rs2, imm) to (word, op_valido).
- The top level holds the handshake, counters, and output register.

Test Plan:
1. ADD rd=3, rs1=1, rs2=2, with wr_ready=1 -> one cycle later wr_valid=1, wr_addr=0, wr_data=0x002081B3; after that cycle, contagem=1.
2. ADDI rd=5, rs1=0, imm=0xFFF, then SH rs1=1, rs2=2, imm=4, then BNE rs1=1, rs2=2, imm=4, back to back -> wr_data is 0xFFF00293, 0x00209223, 0x00209463 at addresses 0, 1, 2 on consecutive cycles.
3. Backpressure: wr_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 after the first accept; wr_addr/wr_data hold; on release, words drain in order with no loss and no duplication.
4. in_op=7 between two ADDs -> erro_op=1; the second ADD is written at address 1 (no gap); contagem=2.
5. Stream 52 valid bundles with DEPTH=50 -> cheio=1 after the 50th accept; bundles 51–52 are never accepted; contagem=50; the last wr_addr is 49.
6. Assert limpar with wr_valid=1 and wr_ready=0; separately, pulse reset mid-stream -> wr_valid=0 and contagem=0; the next accepted word goes to wr_addr=0 and erro_op is cleared.

Source files
------------

// File: rtl/codificador_instrucoes_pkg.sv
// Shared definitions for the instruction-memory encoder and decoder.
// Holds the op-select encoding used on in_op, the RV32I major opcodes
// and the funct3/funct7 values for the supported subset:
// ADD, OR, SLL, ADDI, LH, SH, BNE.
package codificador_instrucoes_pkg;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpOr   = 3'd1,
    OpSll  = 3'd2,
    OpAddi = 3'd3,
    OpLh   = 3'd4,
    OpSh   = 3'd5,
    OpBne  = 3'd6,
    OpRsvd = 3'd7
  } op_t;

  // Major opcodes
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  // funct3 / funct7
  localparam logic [2:0] F3Add  = 3'b000;
  localparam logic [2:0] F3Or   = 3'b110;
  localparam logic [2:0] F3Sll  = 3'b001;
  localparam logic [2:0] F3Addi = 3'b000;
  localparam logic [2:0] F3Lh   = 3'b001;
  localparam logic [2:0] F3Sh   = 3'b001;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [6:0] F7Zero = 7'b0000000;

endpackage

// File: rtl/codificador_instrucoes_if.sv
// Field-bundle input handshake and memory-write output bus of the encoder.
//   in_valid/in_ready : field bundle handshake (in_op, in_rd, in_rs1, in_rs2, in_imm)
//   wr_valid/wr_ready : memory write handshake (wr_addr, wr_data)
// slave  : encoder view (consumes bundles, produces writes)
// master : environment view (producer of bundles, memory sink)
interface codificador_instrucoes_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [11:0]       in_imm;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/codificador_instrucoes_campos.sv
// codificador_campos: combinational field packer.
//   op, rd, rs1, rs2, imm -> word (RV32I encoding), op_valido (0 for reserved op)
// Fields not used by an op are never placed in the word.
module codificador_campos
  import codificador_instrucoes_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        op_valido
);

  always_comb begin
    word      = '0;
    op_valido = 1'b1;
    case (op_t'(op))
      OpAdd:  word = {F7Zero, rs2, rs1, F3Add, rd, OpcOp};
      OpOr:   word = {F7Zero, rs2, rs1, F3Or, rd, OpcOp};
      OpSll:  word = {F7Zero, rs2, rs1, F3Sll, rd, OpcOp};
      OpAddi: word = {imm, rs1, F3Addi, rd, OpcOpImm};
      OpLh:   word = {imm, rs1, F3Lh, rd, OpcLoad};
      OpSh:   word = {imm[11:5], rs2, rs1, F3Sh, imm[4:0], OpcStore};
      // imm holds byte offset[12:1], so imm[11] is offset bit 12
      OpBne:  word = {imm[11], imm[9:4], rs2, rs1, F3Bne, imm[3:0], imm[10], OpcBranch};
      OpRsvd: op_valido = 1'b0;
      default: op_valido = 1'b0;
    endcase
  end

endmodule

// File: rtl/codificador_instrucoes.sv
// codificador_instrucoes: packs field bundles into RV32I words and issues them
// as sequential instruction-memory writes starting at address 0.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   limpar       : synchronous restart at address 0 (drops any pending write)
//   bus          : bundle input handshake + registered write output (slave view)
//   contagem     : words accepted by the memory
//   cheio        : DEPTH words issued, input closed
//   erro_op      : sticky, a reserved op was consumed
module codificador_instrucoes
  import codificador_instrucoes_pkg::*;
#(
  parameter int unsigned DEPTH  = 50,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     limpar,
  codificador_instrucoes_if.slave  bus,
  output logic [ADDR_W:0]          contagem,
  output logic                     cheio,
  output logic                     erro_op
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] Uno    = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   prox_q, prox_d;
  logic [ADDR_W:0]   contagem_q, contagem_d;
  logic              cheio_q, cheio_d;
  logic              erro_q, erro_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic [31:0] word;
  logic        op_valido;
  logic        aceita, emite, wr_feito;

  codificador_campos u_campos (
    .op        (bus.in_op),
    .rd        (bus.in_rd),
    .rs1       (bus.in_rs1),
    .rs2       (bus.in_rs2),
    .imm       (bus.in_imm),
    .word      (word),
    .op_valido (op_valido)
  );

  // The output stage can take a new word when empty or draining this cycle.
  assign bus.in_ready = !reset && !limpar && !cheio_q && (!wr_valid_q || bus.wr_ready);
  assign aceita       = bus.in_valid && bus.in_ready;
  assign emite        = aceita && op_valido;
  assign wr_feito     = wr_valid_q && bus.wr_ready;

  always_comb begin
    prox_d     = prox_q;
    contagem_d = contagem_q;
    cheio_d    = cheio_q;
    erro_d     = erro_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (limpar) begin
      prox_d     = '0;
      contagem_d = '0;
      cheio_d    = 1'b0;
      erro_d     = 1'b0;
      wr_valid_d = 1'b0;
    end else begin
      if (wr_feito) begin
        contagem_d = contagem_q + Uno;
        wr_valid_d = 1'b0;
      end
      if (emite) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = prox_q[ADDR_W-1:0];
        wr_data_d  = word;
        prox_d     = prox_q + Uno;
        if (prox_d == DepthW) cheio_d = 1'b1;
      end
      // Reserved op: consumed silently, only the sticky flag records it.
      if (aceita && !op_valido) erro_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prox_q     <= '0;
      contagem_q <= '0;
      cheio_q    <= 1'b0;
      erro_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      prox_q     <= prox_d;
      contagem_q <= contagem_d;
      cheio_q    <= cheio_d;
      erro_q     <= erro_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign contagem     = contagem_q;
  assign cheio        = cheio_q;
  assign erro_op      = erro_q;

endmodule
